collision_event_dispatcher: RTL
===============================

// Module: collision_event_dispatcher
// PURPOSE
//  Consumer side of the per-pixel collision interface. Collision levels arrive pixel by pixel
//  (tower/player, tower/enemy-HU, shot/enemy-HD, shot[i]/enemy, shot[i]/tower).
//  Each source is debounced and latched once per frame, then snapshotted at startOfFrame.
//  Snapshots are serialized into a valid/ready event stream for game logic.
//  Per-frame strobes are also produced: shot destroy and player hit.
// PARAMETERS
//  NUM_SHOTS    3  number of shot objects; shot collision buses are NUM_SHOTS wide
//  MIN_OVERLAP  1  collision pixels per frame needed to register a source (1..15)
// PORTS
//  clk                     in   1            system clock
//  reset                   in   1            async, active-high reset
//  startOfFrame            in   1            1-cycle pulse at frame start
//  towerPlayerCollision    in   1            player overlaps tower (this pixel)
//  TowerEnemyHUCollision   in   1            heads-up enemy overlaps tower
//  ShotHeadsDownCollision  in   1            any shot overlaps heads-down enemy
//  ShotEnemyCollision      in   NUM_SHOTS    bit i: shot i overlaps enemy
//  ShotBoxCollision        in   NUM_SHOTS    bit i: shot i overlaps tower
//  evt_valid               out  1            event presented
//  evt_ready               in   1            consumer accepts event
//  evt_code                out  EVT_W        event index (collision_pkg encoding)
//  shot_destroy            out  NUM_SHOTS    1-cycle strobe per shot hit in frame just ended
//  player_hit              out  1            1-cycle strobe, player hit in frame just ended
//  evt_overrun             out  1            sticky: event re-raised before previous consumed
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high.
//    All outputs, counters, flags and pending bits are 0 in reset; FSM returns to IDLE.
//  - Event order (bit index = code):
//    0 TOWER_PLAYER, 1 HU_TOWER, 2 SHOT_HD, 3..3+N-1 SHOT_ENEMY[i], 3+N..2+2N SHOT_TOWER[i].
//    NUM_EVT = 3+2*NUM_SHOTS; EVT_W = $clog2(NUM_EVT).
//  - Per source: 4-bit saturating overlap counter. The frame flag sets when the count reaches
//    MIN_OVERLAP and stays set until the frame boundary.
//  - On a startOfFrame cycle:
//    - snapshot <= flags; flags and counters restart.
//    - A collision in that same cycle counts toward the new frame (counter = 1), not the snapshot.
//  - Merge at the same edge: pending <= pending | snapshot.
//    evt_overrun sets if (pending & snapshot) != 0; the overlapping bits merge (event lost).
//  - Strobes, 1 cycle, asserted the cycle after the startOfFrame cycle:
//    - shot_destroy[i] = snapshot SHOT_ENEMY[i] | SHOT_TOWER[i];
//      SHOT_HD is not per-shot and is excluded.
//    - player_hit = snapshot TOWER_PLAYER.
//  - FSM:
//    - IDLE: if pending != 0, load the lowest set index into evt_code, set evt_valid,
//      go to PRESENT. Latency: evt_valid high 2 cycles after the startOfFrame cycle.
//    - PRESENT: evt_valid and evt_code hold stable until evt_valid & evt_ready.
//      On accept, clear that bit. If the remaining pending (including a same-cycle merge) is
//      nonzero, load the next lowest index in the same cycle (back-to-back, 1 event/clk).
//      Otherwise drop evt_valid and go to IDLE.
//  - An accept and a snapshot merge in the same cycle: the accepted bit is cleared first, then the
//    OR is applied, so a re-raised bit survives as a new event and overrun is not set.
//  - evt_ready while IDLE is ignored. Reset mid-PRESENT drops the event.
// CONFIGURATION
//  COLLISION_EVT_COUNTERS_EN defined:
//    - Adds an output evt_count[NUM_EVT][7:0]: per-event saturating count of accepted events.
//    - Cleared only by reset.
//  Undefined: the port and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - collision_pkg holds:
//    - enum evt_code_e with the codes above;
//    - localparams NUM_EVT(NUM_SHOTS) and EVT_W;
//    - a function lowest_set(mask) returning an index.
//  - Sub-module collision_frame_latch (one instance per source): counter, flag,
//    snapshot bit; generated NUM_EVT times.
//  - Top level holds the pending register, merge/overrun logic, FSM and strobes.
// TESTING
//  - Reset asserted mid-PRESENT with evt_code=3 -> all outputs 0 next edge, IDLE;
//    no event after release.
//  - ShotEnemyCollision=3'b010 for 1 pixel, MIN_OVERLAP=1, then SOF:
//    - shot_destroy=3'b010 for 1 cycle;
//    - evt_code=4 with valid 2 cycles after SOF;
//    - valid drops after accept.
//  - MIN_OVERLAP=3, towerPlayerCollision high 2 pixels, then SOF -> no player_hit, no event.
//    With 3 pixels -> player_hit pulse and evt_code=0.
//  - Frame sets codes 0, 2 and 8 with evt_ready held 1 -> codes 0, 2, 8 on consecutive cycles,
//    then valid=0.
//  - evt_ready=0, code 1 pending, next SOF re-raises code 1 -> evt_overrun=1; a single code 1
//    remains. Accept on the SOF cycle instead -> no overrun, code 1 presented again.
//  - Collision on the exact SOF cycle -> absent from that snapshot;
//    appears as an event after the following SOF.

Source files
------------

// File: rtl/collision_event_dispatcher_pkg.sv
// Shared event encoding and sizing helpers for the collision event dispatcher.
// Event index doubles as the pending-bit position and the evt_code value.
package collision_pkg;

   localparam int NUM_SHOTS_DEF = 3;
   localparam int MAX_EVT       = 32;

   function automatic int num_evt(input int n_shots);
      num_evt = 3 + 2 * n_shots;
   endfunction

   function automatic int evt_w(input int n_shots);
      evt_w = $clog2(3 + 2 * n_shots);
   endfunction

   localparam int NUM_EVT = num_evt(NUM_SHOTS_DEF);
   localparam int EVT_W   = evt_w(NUM_SHOTS_DEF);

   typedef enum logic [EVT_W-1:0] {
      EVT_TOWER_PLAYER  = 0,
      EVT_HU_TOWER      = 1,
      EVT_SHOT_HD       = 2,
      EVT_SHOT_ENEMY_0  = 3,
      EVT_SHOT_ENEMY_1  = 4,
      EVT_SHOT_ENEMY_2  = 5,
      EVT_SHOT_TOWER_0  = 6,
      EVT_SHOT_TOWER_1  = 7,
      EVT_SHOT_TOWER_2  = 8
   } evt_code_e;

   // Returns 0 for an empty mask; callers only use it when the mask is nonzero.
   function automatic int unsigned lowest_set(input logic [MAX_EVT-1:0] mask);
      lowest_set = 0;
      for (int i = MAX_EVT - 1; i >= 0; i--) begin
         if (mask[i]) lowest_set = i;
      end
   endfunction

endpackage

// File: rtl/collision_event_dispatcher_if.sv
// Bundle of per-pixel collision inputs and the event/strobe outputs.
// COLLISION_EVT_COUNTERS_EN adds the per-event accept counters.
interface collision_event_dispatcher_if #(
   parameter int NUM_SHOTS = 3
);
   import collision_pkg::*;

   localparam int EVT_W = evt_w(NUM_SHOTS);

   logic                 startOfFrame;
   logic                 towerPlayerCollision;
   logic                 TowerEnemyHUCollision;
   logic                 ShotHeadsDownCollision;
   logic [NUM_SHOTS-1:0] ShotEnemyCollision;
   logic [NUM_SHOTS-1:0] ShotBoxCollision;

   logic                 evt_valid;
   logic                 evt_ready;
   logic [EVT_W-1:0]     evt_code;
   logic [NUM_SHOTS-1:0] shot_destroy;
   logic                 player_hit;
   logic                 evt_overrun;

`ifdef COLLISION_EVT_COUNTERS_EN
   localparam int NUM_EVT = num_evt(NUM_SHOTS);

   logic [7:0]           evt_count [NUM_EVT];

   modport master (
      output startOfFrame, towerPlayerCollision, TowerEnemyHUCollision,
             ShotHeadsDownCollision, ShotEnemyCollision, ShotBoxCollision, evt_ready,
      input  evt_valid, evt_code, shot_destroy, player_hit, evt_overrun, evt_count
   );

   modport slave (
      input  startOfFrame, towerPlayerCollision, TowerEnemyHUCollision,
             ShotHeadsDownCollision, ShotEnemyCollision, ShotBoxCollision, evt_ready,
      output evt_valid, evt_code, shot_destroy, player_hit, evt_overrun, evt_count
   );
`else
   modport master (
      output startOfFrame, towerPlayerCollision, TowerEnemyHUCollision,
             ShotHeadsDownCollision, ShotEnemyCollision, ShotBoxCollision, evt_ready,
      input  evt_valid, evt_code, shot_destroy, player_hit, evt_overrun
   );

   modport slave (
      input  startOfFrame, towerPlayerCollision, TowerEnemyHUCollision,
             ShotHeadsDownCollision, ShotEnemyCollision, ShotBoxCollision, evt_ready,
      output evt_valid, evt_code, shot_destroy, player_hit, evt_overrun
   );
`endif

endinterface

// File: rtl/collision_event_dispatcher_frame_latch.sv
// One collision source: saturating per-frame overlap counter, frame flag and
// the snapshot of that flag taken at startOfFrame.
module collision_frame_latch
   import collision_pkg::*;
#(
   parameter int MIN_OVERLAP = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_sof,
   input  logic i_hit,
   output logic o_flag,
   output logic o_snap
);

   localparam logic [3:0] MIN_L = 4'(MIN_OVERLAP);

   logic [3:0] r_cnt;
   logic       r_flag;
   logic       r_snap;
   logic [3:0] w_cnt_inc;

   assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

   // A hit on the SOF cycle belongs to the new frame, never to the snapshot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= 4'd0;
         r_flag <= 1'b0;
         r_snap <= 1'b0;
      end else if (i_sof) begin
         r_snap <= r_flag;
         r_cnt  <= i_hit ? 4'd1 : 4'd0;
         r_flag <= i_hit && (MIN_L == 4'd1);
      end else if (i_hit) begin
         r_cnt  <= w_cnt_inc;
         r_flag <= r_flag | (w_cnt_inc >= MIN_L);
      end
   end

   assign o_flag = r_flag;
   assign o_snap = r_snap;

endmodule

// File: rtl/collision_event_dispatcher.sv
// Collision event dispatcher: per-source frame latches, pending merge, event FSM and strobes.
// Define COLLISION_EVT_COUNTERS_EN to add per-event saturating accept counters.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | nothing presented; waits for a pending bit
//   S_PRESENT | evt_valid high, evt_code held until accepted
module collision_event_dispatcher
   import collision_pkg::*;
#(
   parameter int NUM_SHOTS   = 3,
   parameter int MIN_OVERLAP = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   collision_event_dispatcher_if.slave  bus
);

   localparam int NUM_EVT = num_evt(NUM_SHOTS);
   localparam int EVT_W   = evt_w(NUM_SHOTS);
   localparam int SE_LO   = 3;
   localparam int ST_LO   = 3 + NUM_SHOTS;

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_PRESENT = 1'b1;

   logic [NUM_EVT-1:0] w_hit;
   logic [NUM_EVT-1:0] w_flag;
   logic [NUM_EVT-1:0] w_snap;
   logic [NUM_EVT-1:0] w_snap_in;
   logic [NUM_EVT-1:0] w_clr;
   logic [NUM_EVT-1:0] w_pend_kept;
   logic [NUM_EVT-1:0] w_pend_next;
   logic               w_accept;
   logic               w_unused_snap;

   logic [0:0]         r_state;
   logic [NUM_EVT-1:0] r_pend;
   logic               r_valid;
   logic [EVT_W-1:0]   r_code;
   logic               r_overrun;
   logic               r_sof_d;

   assign w_hit = {bus.ShotBoxCollision, bus.ShotEnemyCollision, bus.ShotHeadsDownCollision,
                   bus.TowerEnemyHUCollision, bus.towerPlayerCollision};

   for (genvar g = 0; g < NUM_EVT; g++) begin : g_src
      collision_frame_latch #(
         .MIN_OVERLAP (MIN_OVERLAP)
      ) u_latch (
         .clk    (clk),
         .reset  (reset),
         .i_sof  (bus.startOfFrame),
         .i_hit  (w_hit[g]),
         .o_flag (w_flag[g]),
         .o_snap (w_snap[g])
      );
   end

   // Accepted bit is cleared before the snapshot OR, so a re-raise is a fresh event.
   always_comb begin
      w_snap_in = bus.startOfFrame ? w_flag : '0;
      w_accept  = (r_state == S_PRESENT) && bus.evt_ready;
      w_clr     = '0;
      for (int i = 0; i < NUM_EVT; i++) begin
         w_clr[i] = w_accept && (r_code == EVT_W'(i));
      end
      w_pend_kept = r_pend & ~w_clr;
      w_pend_next = w_pend_kept | w_snap_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pend    <= '0;
         r_valid   <= 1'b0;
         r_code    <= '0;
         r_overrun <= 1'b0;
         r_sof_d   <= 1'b0;
      end else begin
         r_pend  <= w_pend_next;
         r_sof_d <= bus.startOfFrame;
         if (|(w_pend_kept & w_snap_in)) r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (|r_pend) begin
                  r_code  <= EVT_W'(lowest_set(MAX_EVT'(r_pend)));
                  r_valid <= 1'b1;
                  r_state <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (w_accept) begin
                  if (|w_pend_next) begin
                     r_code <= EVT_W'(lowest_set(MAX_EVT'(w_pend_next)));
                  end else begin
                     r_code  <= '0;
                     r_valid <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.evt_valid   = r_valid;
   assign bus.evt_code    = r_code;
   assign bus.evt_overrun = r_overrun;

   // Snapshot holds all frame long; gating with the delayed SOF makes 1-cycle strobes.
   assign bus.shot_destroy = r_sof_d ? (w_snap[SE_LO +: NUM_SHOTS] | w_snap[ST_LO +: NUM_SHOTS])
                                     : '0;
   assign bus.player_hit   = r_sof_d & w_snap[EVT_TOWER_PLAYER];
   assign w_unused_snap    = w_snap[EVT_HU_TOWER] | w_snap[EVT_SHOT_HD];

`ifdef COLLISION_EVT_COUNTERS_EN
   logic [7:0] r_evt_count [NUM_EVT];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_EVT; i++) r_evt_count[i] <= 8'd0;
      end else begin
         for (int i = 0; i < NUM_EVT; i++) begin
            if (w_clr[i] && (r_evt_count[i] != 8'hFF)) r_evt_count[i] <= r_evt_count[i] + 8'd1;
         end
      end
   end

   assign bus.evt_count = r_evt_count;
`endif

endmodule
